// File: rtl/pio_poll_pkg.sv
// Shared types and bus widths for the PIO polling master.
package pio_poll_pkg;
    localparam int AV_ADDR_W = 2;
    localparam int AV_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/pio_poll_master_if.sv
// Avalon-MM read-only master/slave bundle used by the PIO polling master.
interface pio_poll_master_if
    import pio_poll_pkg::*;
();
    logic [AV_ADDR_W-1:0] address;
    logic                 read;
    logic                 waitrequest;
    logic [AV_DATA_W-1:0] readdata;

    modport master (output address, output read, input waitrequest, input readdata);
    modport slave  (input address, input read, output waitrequest, output readdata);
endinterface

// File: rtl/pio_poll_master_poll_timer.sv
// Poll period timer: counts enabled cycles, flags the last cycle of the period.
module poll_timer #(
    parameter int POLL_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(POLL_CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);
endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that polls a PIO switch register and flags value changes.
//  state | meaning
//  IDLE  | counting the poll period, waiting for a launch condition
//  REQ   | read command on the bus, held until waitrequest drops
//  WAIT  | command accepted, counting down the fixed slave read latency
module pio_poll_master
    import pio_poll_pkg::*;
#(
    parameter int                   DATA_W       = 18,
    parameter int                   POLL_CYCLES  = 1000,
    parameter int                   READ_LATENCY = 1,
    parameter logic [AV_ADDR_W-1:0] PIO_ADDR     = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pio_poll_master_if.master      bus,
    input  logic                   enable,
    input  logic                   poll_now,
    output logic [DATA_W-1:0]      sw_value,
    output logic                   sw_valid,
    output logic                   sw_changed
);
    localparam logic [1:0] LAT_LD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    state_t            state, state_nxt;
    logic [1:0]        lat_cnt, lat_nxt;
    logic              pending;
    logic              tc;
    logic              launch;
    logic              capture;
    logic [DATA_W-1:0] new_val;
    logic              unused_hi;

    assign launch    = (state == IDLE) && ((enable && tc) || poll_now || pending);
    assign new_val   = bus.readdata[DATA_W-1:0];
    assign unused_hi = ^(bus.readdata >> DATA_W);

    poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .en      ((state == IDLE) && enable),
        .clr     (launch),
        .tc      (tc)
    );

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_nxt = REQ;
            end
            REQ: begin
                if (!bus.waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        capture   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        lat_nxt   = LAT_LD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    lat_nxt = lat_cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.read    = (state == REQ);
    assign bus.address = (state == REQ) ? PIO_ADDR : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            // Only one extra poll can be queued behind the one in flight.
            if (launch) begin
                pending <= 1'b0;
            end else if ((state != IDLE) && poll_now) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_value   <= '0;
            sw_valid   <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= capture && (!sw_valid || (new_val != sw_value));
            if (capture) begin
                sw_value <= new_val;
                sw_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master: latency-1 build against a transaction model, latency-0 build by hand.
module tb_pio_poll_master;
    import pio_poll_pkg::*;

    localparam int POLL = 4;
    localparam int DW   = 18;
    localparam int RL   = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable = 1'b0;
    logic          poll_now = 1'b0;
    logic          pn0 = 1'b0;
    logic          wreq = 1'b0;
    logic [31:0]   rdata = 32'h2A5;
    logic [DW-1:0] v1, v0;
    logic          val1, val0, ch1, ch0;

    int n_vec = 0;
    int n_err = 0;
    int n_rise = 0;
    int n_hi = 0;
    int n_chg = 0;
    logic r_prev = 1'b0;

    always #5 clk = ~clk;

    pio_poll_master_if bus1();
    pio_poll_master_if bus0();
    assign bus1.readdata    = rdata;
    assign bus1.waitrequest = wreq;
    assign bus0.readdata    = rdata;
    assign bus0.waitrequest = 1'b0;

    pio_poll_master #(.DATA_W(DW), .POLL_CYCLES(POLL), .READ_LATENCY(RL), .PIO_ADDR(2'd0)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.master), .enable(enable), .poll_now(poll_now),
        .sw_value(v1), .sw_valid(val1), .sw_changed(ch1)
    );

    pio_poll_master #(.DATA_W(DW), .POLL_CYCLES(POLL), .READ_LATENCY(0), .PIO_ADDR(2'd0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.master), .enable(1'b0), .poll_now(pn0),
        .sw_value(v0), .sw_valid(val0), .sw_changed(ch0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a poll is "busy" from launch until the capture that ends it;
    // m_age counts cycles since the slave accepted the command (-1 = not yet accepted).
    bit            m_busy = 0, m_pending = 0, m_valid = 0, m_changed = 0;
    int            m_timer = 0, m_age = -1;
    logic [DW-1:0] m_val = '0;
    logic [DW-1:0] m_new;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_pending = 0; m_valid = 0; m_changed = 0;
            m_timer = 0; m_age = -1; m_val = '0;
        end else begin
            m_changed = 0;
            if (!m_busy) begin
                if ((enable && m_timer == POLL - 1) || poll_now || m_pending) begin
                    m_busy = 1; m_age = -1; m_timer = 0; m_pending = 0;
                end else if (enable) begin
                    m_timer++;
                end
            end else begin
                if (poll_now) m_pending = 1;
                if (m_age < 0) begin
                    if (!wreq) m_age = 0;
                end else begin
                    m_age++;
                end
                if (m_age == RL) begin
                    m_new     = rdata[DW-1:0];
                    m_changed = !m_valid || (m_new != m_val);
                    m_val     = m_new;
                    m_valid   = 1;
                    m_busy    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("read",       {31'd0, bus1.read}, {31'd0, (m_busy && m_age < 0)});
        check("address",    {30'd0, bus1.address}, 32'd0);
        check("sw_value",   {14'd0, v1}, {14'd0, m_val});
        check("sw_valid",   {31'd0, val1}, {31'd0, m_valid});
        check("sw_changed", {31'd0, ch1}, {31'd0, m_changed});
        if (bus1.read && !r_prev) n_rise++;
        if (bus1.read) n_hi++;
        if (ch1) n_chg++;
        r_prev = bus1.read;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_rd(input logic lvl, input int max, output int cyc);
        cyc = 0;
        while (bus1.read !== lvl && cyc < max) begin
            tick(1);
            cyc++;
        end
        if (bus1.read !== lvl) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_read: read=%b, expected %b within %0d cycles", bus1.read, lvl, max);
        end
    endtask

    int cyc;

    initial begin
        #1 reset_n = 1'b0;
        #1;
        check("rst_read", {31'd0, bus1.read}, 32'd0);
        check("rst_valid", {31'd0, val1}, 32'd0);
        tick(3);
        reset_n = 1'b1;

        // First periodic poll: 4 enabled idle cycles, 1-cycle latency
        enable = 1'b1;
        wait_rd(1'b1, 20, cyc);
        check("t2_launch_delay", cyc, 32'd4);
        wait_rd(1'b0, 10, cyc);
        check("t2_req_len", cyc, 32'd1);
        tick(1);
        check("t2_changed", {31'd0, ch1}, 32'd1);
        check("t2_value", {14'd0, v1}, 32'h2A5);
        check("t2_valid", {31'd0, val1}, 32'd1);
        tick(1);
        check("t2_pulse_end", {31'd0, ch1}, 32'd0);

        // Same value then a one-bit change
        n_chg = 0;
        wait_rd(1'b1, 20, cyc);
        wait_rd(1'b0, 10, cyc);
        tick(2);
        check("t3_nochange", n_chg, 32'd0);
        rdata = 32'h2A4;
        wait_rd(1'b1, 20, cyc);
        wait_rd(1'b0, 10, cyc);
        tick(2);
        check("t3_change_cnt", n_chg, 32'd1);
        check("t3_value", {14'd0, v1}, 32'h2A4);

        // Stall for 3 cycles in REQ
        enable = 1'b0;
        tick(6);
        rdata = 32'h155;
        wreq = 1'b1;
        poll_now = 1'b1;
        n_hi = 0;
        tick(1);
        poll_now = 1'b0;
        check("t4_read_up", {31'd0, bus1.read}, 32'd1);
        tick(3);
        wreq = 1'b0;
        tick(1);
        check("t4_read_down", {31'd0, bus1.read}, 32'd0);
        check("t4_read_cycles", n_hi, 32'd4);
        check("t4_not_yet", {31'd0, ch1}, 32'd0);
        tick(1);
        check("t4_capture", {31'd0, ch1}, 32'd1);
        check("t4_value", {14'd0, v1}, 32'h155);

        // poll_now during WAIT queues exactly one extra read
        tick(3);
        n_rise = 0;
        poll_now = 1'b1;
        tick(1);
        poll_now = 1'b0;
        tick(1);
        check("t5_in_wait", {31'd0, bus1.read}, 32'd0);
        poll_now = 1'b1;
        tick(1);
        poll_now = 1'b0;
        check("t5_idle_gap", {31'd0, bus1.read}, 32'd0);
        tick(1);
        check("t5_pending_req", {31'd0, bus1.read}, 32'd1);
        tick(20);
        check("t5_read_count", n_rise, 32'd2);

        // Upper readdata bits ignored
        rdata = 32'hFFFF_FFFF;
        poll_now = 1'b1;
        tick(1);
        poll_now = 1'b0;
        tick(2);
        check("t6_value", {14'd0, v1}, 32'h3FFFF);

        // Zero-latency build captures in the acceptance cycle
        pn0 = 1'b1;
        tick(1);
        pn0 = 1'b0;
        check("rl0_req", {31'd0, bus0.read}, 32'd1);
        check("rl0_valid0", {31'd0, val0}, 32'd0);
        tick(1);
        check("rl0_read_down", {31'd0, bus0.read}, 32'd0);
        check("rl0_valid", {31'd0, val0}, 32'd1);
        check("rl0_value", {14'd0, v0}, 32'h3FFFF);
        check("rl0_changed", {31'd0, ch0}, 32'd1);
        tick(1);
        check("rl0_pulse_end", {31'd0, ch0}, 32'd0);

        // Asynchronous reset in the middle of REQ
        tick(2);
        wreq = 1'b1;
        poll_now = 1'b1;
        tick(1);
        poll_now = 1'b0;
        check("t1_in_req", {31'd0, bus1.read}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t1_read", {31'd0, bus1.read}, 32'd0);
        check("t1_valid", {31'd0, val1}, 32'd0);
        check("t1_changed", {31'd0, ch1}, 32'd0);
        check("t1_value", {14'd0, v1}, 32'd0);
        tick(2);
        wreq = 1'b0;
        reset_n = 1'b1;
        tick(1);
        n_rise = 0;
        poll_now = 1'b1;
        tick(1);
        poll_now = 1'b0;
        check("t1_clean_req", {31'd0, bus1.read}, 32'd1);
        tick(2);
        check("t1_first_capture", {31'd0, ch1}, 32'd1);
        check("t1_valid_again", {31'd0, val1}, 32'd1);
        tick(3);
        check("t1_read_count", n_rise, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
